// File: rtl/reward_timer_ctrl_pkg.sv
// Shared types for the reward timer controller.
// FSM states, reward codes and effect slot indices.
package reward_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_WAIT
  } state_t;

  localparam logic [2:0] RT_INVINCIBLE = 3'd1;
  localparam logic [2:0] RT_FASTER     = 3'd2;
  localparam logic [2:0] RT_FROZEN     = 3'd3;
  localparam logic [2:0] RT_LASER      = 3'd4;

  localparam int unsigned EFF_INVINCIBLE = 0;
  localparam int unsigned EFF_FASTER     = 1;
  localparam int unsigned EFF_FROZEN     = 2;
  localparam int unsigned EFF_LASER      = 3;
  localparam int unsigned NUM_EFF        = 4;

endpackage

// File: rtl/reward_effect_counter.sv
// One effect lifetime down-counter.
// Clear beats load, load beats decrement, zero holds.
module reward_effect_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count
);

  // load / decrement / hold, never wrapping below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - CNT_W'(1);
  end

endmodule

// File: rtl/reward_timer_ctrl.sv
// Reward pickup controller with four timed effects.
// tick_4Hz is sampled as data and turned into tick_en.
module reward_timer_ctrl
  import reward_timer_ctrl_pkg::*;
#(
  parameter int DURATION = 20,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_4Hz,
  input  logic             enable,
  input  logic             pickup_valid,
  input  logic [2:0]       pickup_type,
  input  logic             mode_classic,
  input  logic             mode_infinity,
  output logic             pickup_ready,
  output logic             pickup_done,
  output logic             pickup_err,
  output logic             reward_invincible,
  output logic             reward_faster,
  output logic             reward_frozen,
  output logic             reward_laser,
  output logic             reward_addtime,
  input  logic [1:0]       disp_sel,
  output logic [CNT_W-1:0] disp_remain
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DURATION);

  logic [1:0]       tick_sync;
  logic             tick_d;
  logic             tick_en;
  logic             run;
  state_t           state;
  state_t           state_nxt;
  logic [2:0]       type_q;
  logic [NUM_EFF-1:0] load_vec;
  logic [CNT_W-1:0] cnt [NUM_EFF];

  // two-flop synchroniser plus edge detector on the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_sync <= '0;
      tick_d    <= 1'b0;
    end else begin
      tick_sync <= {tick_sync[0], tick_4Hz};
      tick_d    <= tick_sync[1];
    end
  end

  assign tick_en = tick_sync[1] & ~tick_d;

  // state register, first-clock flag and captured code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      run    <= 1'b0;
      type_q <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (pickup_valid && pickup_ready)
        type_q <= pickup_type;
    end
  end

  // next state, handshake and reward decode
  always_comb begin
    state_nxt      = state;
    pickup_ready   = 1'b0;
    pickup_done    = 1'b0;
    pickup_err     = 1'b0;
    reward_addtime = 1'b0;
    load_vec       = '0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          pickup_ready = run;
          if (pickup_valid && run)
            state_nxt = ST_LOAD;
        end
        ST_LOAD: begin
          state_nxt = ST_DONE;
          unique case (1'b1)
            (type_q == RT_INVINCIBLE): begin
              if (mode_classic)
                load_vec[EFF_INVINCIBLE] = 1'b1;
              else if (mode_infinity)
                reward_addtime = 1'b1;
              else
                pickup_err = 1'b1;
            end
            (type_q == RT_FASTER):
              load_vec[EFF_FASTER] = 1'b1;
            (type_q == RT_FROZEN):
              load_vec[EFF_FROZEN] = 1'b1;
            (type_q == RT_LASER):
              load_vec[EFF_LASER] = 1'b1;
            default:
              pickup_err = 1'b1;
          endcase
        end
        ST_DONE: begin
          pickup_done = 1'b1;
          state_nxt   = ST_WAIT;
        end
        ST_WAIT: begin
          if (!pickup_valid)
            state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_EFF; g++) begin : g_eff
    reward_effect_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (~enable),
      .load    (load_vec[g]),
      .dec     (tick_en),
      .load_val(LOAD_VAL),
      .count   (cnt[g])
    );
  end

  assign reward_invincible = cnt[EFF_INVINCIBLE] != '0;
  assign reward_faster     = cnt[EFF_FASTER] != '0;
  assign reward_frozen     = cnt[EFF_FROZEN] != '0;
  assign reward_laser      = cnt[EFF_LASER] != '0;

  // display mux of the selected counter
  always_comb begin
    disp_remain = cnt[disp_sel];
  end

endmodule

// File: tb/tb_reward_timer_ctrl.sv
// Directed bench for reward_timer_ctrl.
// Expected values queue up at stimulus, compare at output.
module tb_reward_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_4Hz;
  logic       enable;
  logic       pickup_valid;
  logic [2:0] pickup_type;
  logic       mode_classic;
  logic       mode_infinity;
  logic       pickup_ready;
  logic       pickup_done;
  logic       pickup_err;
  logic       reward_invincible;
  logic       reward_faster;
  logic       reward_frozen;
  logic       reward_laser;
  logic       reward_addtime;
  logic [1:0] disp_sel;
  logic [4:0] disp_remain;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;
  logic [31:0] sb [$];

  reward_timer_ctrl #(
    .DURATION(20),
    .CNT_W   (5)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tick_4Hz         (tick_4Hz),
    .enable           (enable),
    .pickup_valid     (pickup_valid),
    .pickup_type      (pickup_type),
    .mode_classic     (mode_classic),
    .mode_infinity    (mode_infinity),
    .pickup_ready     (pickup_ready),
    .pickup_done      (pickup_done),
    .pickup_err       (pickup_err),
    .reward_invincible(reward_invincible),
    .reward_faster    (reward_faster),
    .reward_frozen    (reward_frozen),
    .reward_laser     (reward_laser),
    .reward_addtime   (reward_addtime),
    .disp_sel         (disp_sel),
    .disp_remain      (disp_remain)
  );

  always #5 clk = ~clk;

  wire [3:0] effs = {reward_laser, reward_frozen,
                     reward_faster, reward_invincible};
  wire [12:0] all_out = {pickup_ready, pickup_done, pickup_err,
                         effs, reward_addtime, disp_remain};

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    ntot++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL %s: no expected entry, observed %0d", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) npass++;
      else begin
        nfail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic give_tick();
    tick_4Hz = 1'b1;
    repeat (4) step();
    tick_4Hz = 1'b0;
    repeat (3) step();
  endtask

  task automatic pickup(input logic [2:0] t,
                        output logic err_l, output logic add_l,
                        output logic done_l, output logic done_d,
                        output logic add_d);
    int k = 0;
    while (!pickup_ready && k < 20) begin
      step();
      k++;
    end
    if (!pickup_ready) begin
      ntot++;
      nfail++;
      $error("FAIL ready_timeout: observed 0 expected 1");
    end
    pickup_valid = 1'b1;
    pickup_type  = t;
    step();
    pickup_valid = 1'b0;
    err_l  = pickup_err;
    add_l  = reward_addtime;
    done_l = pickup_done;
    step();
    done_d = pickup_done;
    add_d  = reward_addtime;
    step();
    step();
  endtask

  initial begin
    logic e_l, a_l, d_l, d_d, a_d;
    int n;
    rst = 1'b1;
    tick_4Hz = 1'b0;
    enable = 1'b1;
    pickup_valid = 1'b0;
    pickup_type = 3'd0;
    mode_classic = 1'b0;
    mode_infinity = 1'b0;
    disp_sel = 2'd0;

    #2;
    push(0); chk("reset_outputs", all_out);
    step();
    step();
    rst = 1'b0;
    push(0); chk("ready_before_first_clk", pickup_ready);
    step();
    push(1); chk("ready_idle", pickup_ready);

    // type 2: done two clocks after accept, 20 ticks of faster
    disp_sel = 2'd1;
    push(0); push(1); push(0);
    pickup(3'd2, e_l, a_l, d_l, d_d, a_d);
    chk("t2_done_in_load", d_l);
    chk("t2_done_pulse", d_d);
    chk("t2_err", e_l);
    push(20); chk("t2_remain_full", disp_remain);
    push(1); chk("t2_faster_on", reward_faster);
    repeat (10) give_tick();
    push(10); chk("t2_remain_half", disp_remain);
    n = 10;
    while (reward_faster && n < 30) begin
      give_tick();
      n++;
    end
    push(20); chk("t2_tick_count", n);
    give_tick();
    push(0); chk("t2_no_wrap", disp_remain);

    // type 1 infinity: addtime only
    mode_infinity = 1'b1;
    push(1); push(0); push(0);
    pickup(3'd1, e_l, a_l, d_l, d_d, a_d);
    chk("inf_addtime", a_l);
    chk("inf_addtime_one_cycle", a_d);
    chk("inf_no_err", e_l);
    push(0); chk("inf_no_invincible", reward_invincible);

    // type 1 classic: invincible
    mode_infinity = 1'b0;
    mode_classic = 1'b1;
    disp_sel = 2'd0;
    pickup(3'd1, e_l, a_l, d_l, d_d, a_d);
    push(20); chk("classic_inv_remain", disp_remain);
    push(0); chk("classic_no_addtime", a_l);

    // type 4 re-pickup at 3, plain and with coincident tick
    disp_sel = 2'd3;
    pickup(3'd4, e_l, a_l, d_l, d_d, a_d);
    repeat (17) give_tick();
    push(3); chk("laser_at_3", disp_remain);
    pickup(3'd4, e_l, a_l, d_l, d_d, a_d);
    push(20); chk("laser_reload", disp_remain);
    repeat (17) give_tick();
    push(3); chk("laser_at_3_again", disp_remain);
    push(0); chk("inv_expired", reward_invincible);
    tick_4Hz = 1'b1;
    step();
    pickup_valid = 1'b1;
    pickup_type = 3'd4;
    step();
    pickup_valid = 1'b0;
    push(3); chk("laser_in_load", disp_remain);
    step();
    push(20); chk("laser_reload_vs_tick", disp_remain);
    tick_4Hz = 1'b0;
    repeat (3) step();
    push(20); chk("laser_after_reload", disp_remain);

    // valid held 10 clk: one done
    n = 0;
    pickup_valid = 1'b1;
    pickup_type = 3'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pickup_done) n++;
    end
    pickup_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pickup_done) n++;
    end
    push(1); chk("held_valid_one_done", n);

    // illegal codes
    push(1);
    pickup(3'd6, e_l, a_l, d_l, d_d, a_d);
    chk("t6_err", e_l);
    push(4'b1100); chk("t6_no_effect", effs);
    disp_sel = 2'd2;
    push(20); chk("t6_frozen_intact", disp_remain);
    mode_classic = 1'b0;
    push(1); push(0);
    pickup(3'd1, e_l, a_l, d_l, d_d, a_d);
    chk("nomode_err", e_l);
    chk("nomode_no_addtime", a_l);
    push(0); chk("nomode_no_inv", reward_invincible);

    // enable drop
    enable = 1'b0;
    step();
    push(0); chk("disable_effects", effs);
    push(0); chk("disable_ready", pickup_ready);
    give_tick();
    push(0); chk("disable_hold", disp_remain);
    enable = 1'b1;
    step();
    push(1); chk("reenable_ready", pickup_ready);

    // reset in LOAD
    mode_classic = 1'b1;
    pickup_valid = 1'b1;
    pickup_type = 3'd2;
    step();
    rst = 1'b1;
    #1;
    push(0); chk("rst_in_load_outputs", all_out);
    pickup_valid = 1'b0;
    n = 0;
    repeat (2) begin
      step();
      if (pickup_done) n++;
    end
    rst = 1'b0;
    repeat (4) begin
      step();
      if (pickup_done) n++;
    end
    push(0); chk("rst_no_done", n);
    push(0); chk("rst_no_load", reward_faster);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/reward_timer_ctrl.md
REWARD_TIMER_CTRL -- requirements
Module: reward_timer_ctrl

Interface
REQ-001 SHALL have parameter DURATION, default 20, effect lifetime in 4 Hz ticks (legal 1..31).
REQ-002 SHALL have parameter CNT_W, default 5, width of each effect down-counter.
REQ-003 SHALL have ports: clk  in  1  system clock (sole clock); rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: tick_4Hz  in  1  free-running 4 Hz square wave, treated as data and never used as a clock.
REQ-005 SHALL have ports: enable  in  1  game running; pickup_valid  in  1  pickup request; pickup_type  in  3  reward code 1..4.
REQ-006 SHALL have ports: mode_classic  in  1; mode_infinity  in  1  game mode selects.
REQ-007 SHALL have ports: pickup_ready  out  1; pickup_done  out  1  one-cycle completion pulse; pickup_err  out  1  one-cycle pulse for an illegal code.
REQ-008 SHALL have ports: reward_invincible, reward_faster, reward_frozen, reward_laser  out  1 each  effect-active levels; reward_addtime  out  1  one-cycle pulse.
REQ-009 SHALL have ports: disp_sel  in  2  effect index for display; disp_remain  out  CNT_W  remaining ticks of the selected effect.

Function
REQ-010 SHALL synchronise tick_4Hz with a 2-flop synchroniser and derive tick_en, a one-clk pulse on each synchronised rising edge.
REQ-011 SHALL hold four independent counters: index 0 invincible, 1 faster, 2 frozen, 3 laser.
REQ-012 SHALL drive each effect level high exactly while its counter is nonzero.
REQ-013 SHALL decrement every nonzero counter by 1 on tick_en and hold any counter already at 0; counters SHALL never wrap.
REQ-014 SHALL implement FSM IDLE -> LOAD -> DONE -> WAIT -> IDLE.
REQ-015 SHALL assert pickup_ready only in IDLE with enable high; pickup_valid & pickup_ready SHALL move the FSM to LOAD and capture pickup_type.
REQ-016 In LOAD, type 1 with mode_classic SHALL load counter 0 with DURATION.
REQ-017 In LOAD, type 1 with mode_infinity and not mode_classic SHALL pulse reward_addtime for one cycle.
REQ-018 In LOAD, types 2/3/4 SHALL load counters 1/2/3 respectively with DURATION.
REQ-019 In LOAD, any other type, or type 1 with neither mode set, SHALL pulse pickup_err and load nothing.
REQ-020 A re-pickup of an already active effect SHALL reload DURATION.
REQ-021 When a load and tick_en hit the same counter in the same cycle, the load SHALL win.
REQ-022 DONE SHALL pulse pickup_done for exactly one cycle, 2 clk after acceptance.
REQ-023 WAIT SHALL hold until pickup_valid is low, then return to IDLE, so one request yields exactly one pickup.
REQ-024 enable low SHALL clear all counters within 1 clk, force the FSM to IDLE, and suppress pending pulses; counters SHALL stay 0 while enable is low.
REQ-025 disp_remain SHALL be a combinational mux of the counter selected by disp_sel.

Reset
REQ-026 On rst high, asynchronously: all counters 0, FSM IDLE, synchroniser flops 0, and all outputs 0 (pickup_ready 0 until the first clk after release).
REQ-027 rst asserted mid-pickup SHALL abandon the request, with no pickup_done and no load.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration, the reward-type codes (1..4), and the effect index constants.
REQ-029 One sub-module, reward_effect_counter (load/decrement/hold with parameter CNT_W), SHALL be instantiated four times.

Verification
REQ-030 Bench SHALL cover: pickup type 2 in IDLE -> pickup_done 2 clk later; reward_faster high for exactly 20 tick_en pulses, then low.
REQ-031 Bench SHALL cover: type 1 with mode_infinity=1, mode_classic=0 -> one-cycle reward_addtime pulse; reward_invincible stays 0.
REQ-032 Bench SHALL cover: type 4 re-picked when disp_remain=3 (disp_sel=3) -> disp_remain=20 on the next cycle, including when tick_en coincides.
REQ-033 Bench SHALL cover: pickup_valid held high for 10 clk -> exactly one pickup_done; type 6 -> pickup_err pulse and no effect.
REQ-034 Bench SHALL cover: enable dropped with effects active -> all effect outputs 0 next cycle; rst asserted in LOAD -> all outputs 0 immediately, no pickup_done.
